// File: rtl/iob_cache_rd_pkg.sv
// rtl/iob_cache_rd_pkg.sv - state encoding and width helpers for the cache line-fill read channel
package iob_cache_rd_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HANDSHAKE = 2'd1;
    localparam logic [1:0] END       = 2'd2;

    // log2 of bytes per word for a word of data_w bits
    function automatic int calc_nbytes_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // log2 of back-end beats per cache line
    function automatic int calc_line2be_w(input int word_offset_w, input int data_w,
                                          input int be_data_w);
        return word_offset_w - $clog2(be_data_w / data_w);
    endfunction

endpackage

// File: rtl/iob_cache_rd_beat_ctr.sv
// rtl/iob_cache_rd_beat_ctr.sv - modulo-2^W beat counter with load, enable and last-beat flag
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low clear (count returns to 0)
//   load     load load_val (wins over en)
//   load_val value loaded on load
//   en       advance by one, wrapping modulo 2^W
//   cnt      current count
//   last     cnt is all-ones (always 1 when W=0)
module iob_cache_rd_beat_ctr #(
    parameter  int W  = 2,
    localparam int CW = (W > 0) ? W : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    // With W=0 there is a single beat per line: the mask pins the count at 0.
    localparam logic [CW-1:0] MASK = (W == 0) ? '0 : '1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val & MASK;
        end else if (en) begin
            cnt_q <= (cnt_q + 1'b1) & MASK;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == MASK);

endmodule

// File: rtl/iob_cache_read_channel.sv
// rtl/iob_cache_read_channel.sv - cache line-fill engine streaming back-end beats into the data memory
//
// Optional feature: define IOB_CACHE_RD_WRAP_FIRST_EN for critical-word-first fills
// (beat index starts at the missing word's back-end word and wraps around the line).
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   replace_valid/addr      line-fill request and front-end word address of the miss
//   replace                 fill in progress
//   read_valid/addr/data    one back-end word written into the line at beat index read_addr
//   be_addr/valid/ready     back-end read request; be_rdata valid when be_ready is high
//   be_rdata                back-end read data
module iob_cache_read_channel
    import iob_cache_rd_pkg::*;
#(
    parameter  int ADDR_W        = 32,
    parameter  int DATA_W        = 32,
    parameter  int BE_ADDR_W     = 32,
    parameter  int BE_DATA_W     = 32,
    parameter  int WORD_OFFSET_W = 3,
    localparam int NBYTES_W      = calc_nbytes_w(DATA_W),
    localparam int BE_NBYTES_W   = calc_nbytes_w(BE_DATA_W),
    localparam int LINE2BE_W     = calc_line2be_w(WORD_OFFSET_W, DATA_W, BE_DATA_W),
    localparam int IDX_W         = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       replace_valid,
    input  logic [ADDR_W-NBYTES_W-1:0] replace_addr,
    output logic                       replace,
    output logic                       read_valid,
    output logic [IDX_W-1:0]           read_addr,
    output logic [BE_DATA_W-1:0]       read_data,
    output logic [BE_ADDR_W-1:0]       be_addr,
    output logic                       be_valid,
    input  logic                       be_ready,
    input  logic [BE_DATA_W-1:0]       be_rdata
);

    localparam int LINE_W = ADDR_W - NBYTES_W - WORD_OFFSET_W;

    logic [1:0]        state;
    logic [LINE_W-1:0] line_addr;
    logic              start;
    logic              beat;
    logic              last_beat;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_start;
    logic              idx_last;
    logic [ADDR_W-1:0] full_addr;
    logic              unused_word_off;

    // The word-offset bits only matter for critical-word-first start positions.
    assign unused_word_off = ^replace_addr[WORD_OFFSET_W-1:0];

    assign start = (state == IDLE) && replace_valid;
    assign beat  = (state == HANDSHAKE) && be_ready;

    iob_cache_rd_beat_ctr #(.W(LINE2BE_W)) u_idx_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (idx_start),
        .en       (beat),
        .cnt      (idx),
        .last     (idx_last)
    );

`ifdef IOB_CACHE_RD_WRAP_FIRST_EN
    logic [IDX_W-1:0] cnt;
    logic             cnt_last;
    logic             unused_idx_last;

    // Start at the back-end word holding the missing front-end word.
    if (LINE2BE_W > 0) begin : g_wrap_start
        assign idx_start = replace_addr[WORD_OFFSET_W-1 -: IDX_W];
    end else begin : g_wrap_start_zero
        assign idx_start = '0;
    end

    // The index wraps, so the end of the burst is detected by a separate beat count.
    iob_cache_rd_beat_ctr #(.W(LINE2BE_W)) u_cnt_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val ('0),
        .en       (beat),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    assign last_beat       = cnt_last;
    assign unused_idx_last = idx_last ^ (^cnt);
`else
    assign idx_start = '0;
    assign last_beat = idx_last;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            line_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (replace_valid) begin
                        state     <= HANDSHAKE;
                        line_addr <= replace_addr[ADDR_W-NBYTES_W-1:WORD_OFFSET_W];
                    end
                end
                HANDSHAKE: begin
                    if (be_ready && last_beat) begin
                        state <= END;
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    if (LINE2BE_W > 0) begin : g_be_addr_idx
        assign full_addr = {line_addr, idx, {BE_NBYTES_W{1'b0}}};
    end else begin : g_be_addr_line
        assign full_addr = {line_addr, {BE_NBYTES_W{1'b0}}};
    end

    assign be_addr    = BE_ADDR_W'(full_addr);
    assign be_valid   = (state == HANDSHAKE);
    assign replace    = (state == HANDSHAKE) || (state == END);
    // A beat arriving in the same cycle as reset is dropped.
    assign read_valid = beat && reset;
    assign read_addr  = idx;
    assign read_data  = be_rdata;

endmodule
